// File: rtl/risc_mem_pkg.sv
// Shared definitions for the processor's data-memory responder:
// the I/O page layout and the access decode targets.
package risc_mem_pkg;

  localparam logic [15:0] IO_BASE_DEF = 16'hFF00;

  localparam logic [1:0] OFS_OUT = 2'd0;
  localparam logic [1:0] OFS_IN  = 2'd1;
  localparam logic [1:0] OFS_CNT = 2'd2;
  localparam logic [1:0] OFS_ERR = 2'd3;

  typedef enum logic [2:0] {
    TGT_RAM,
    TGT_OUT,
    TGT_IN,
    TGT_CNT,
    TGT_ERR,
    TGT_NONE
  } tgt_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Processor-side memory bus: word address, write data, write enable and
// the responder's registered read data.
interface data_mem_responder_if;
  logic        mw_en;
  logic [15:0] Address;
  logic [15:0] D_out;
  logic [15:0] D_in;

  modport master (output mw_en, output Address, output D_out, input D_in);
  modport slave  (input mw_en, input Address, input D_out, output D_in);
endinterface

// File: rtl/data_ram.sv
// Single-port 2^ADDR_W x 16 RAM: synchronous write, registered read,
// read-before-write on a same-address access. Contents are not reset.
module data_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_wdata,
  output logic [15:0]       o_rdata
);

  logic [15:0] r_mem [2**ADDR_W];

  // NOTE: the array is kept out of any reset so it maps onto a RAM macro;
  // a reset branch would force it into discrete flops.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: decodes each bus access to the RAM or the I/O page
// and returns read data one cycle later; flags unmapped accesses in bus_err.
module data_mem_responder
  import risc_mem_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter logic [15:0] IO_BASE    = IO_BASE_DEF,
  parameter logic [15:0] RD_ERR_VAL = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  input  logic [15:0]          sw_in,
  output logic [15:0]          io_out,
  output logic                 bus_err
);

  tgt_e        w_tgt;
  logic [15:0] w_io_rdata;
  logic [15:0] w_ram_rdata;
  logic        w_ram_we;

  logic [15:0] r_io_out;
  logic [15:0] r_sync1;
  logic [15:0] r_sync2;
  logic [15:0] r_cnt;
  logic        r_bus_err;
  logic [15:0] r_io_rdata;
  logic        r_sel_ram;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_tgt = TGT_NONE;
    if ((bus.Address >> ADDR_W) == '0) begin
      w_tgt = TGT_RAM;
    end else if (bus.Address[15:2] == IO_BASE[15:2]) begin
      case (bus.Address[1:0])
        OFS_OUT: w_tgt = TGT_OUT;
        OFS_IN:  w_tgt = TGT_IN;
        OFS_CNT: w_tgt = TGT_CNT;
        OFS_ERR: w_tgt = TGT_ERR;
        default: w_tgt = TGT_NONE;
      endcase
    end
  end

  always_comb begin
    w_io_rdata = RD_ERR_VAL;
    case (w_tgt)
      TGT_OUT: w_io_rdata = r_io_out;
      TGT_IN:  w_io_rdata = r_sync2;
      TGT_CNT: w_io_rdata = r_cnt;
      TGT_ERR: w_io_rdata = {15'b0, r_bus_err};
      default: w_io_rdata = RD_ERR_VAL;
    endcase
  end

  assign w_ram_we = bus.mw_en && (w_tgt == TGT_RAM);

  data_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (bus.Address[ADDR_W-1:0]),
    .i_wdata (bus.D_out),
    .o_rdata (w_ram_rdata)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; this is what makes reads return the value before a write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_io_out   <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_cnt      <= '0;
      r_bus_err  <= 1'b0;
      r_io_rdata <= '0;
      r_sel_ram  <= 1'b0;
    end else begin
      r_sync1    <= sw_in;
      r_sync2    <= r_sync1;
      r_io_rdata <= w_io_rdata;
      r_sel_ram  <= (w_tgt == TGT_RAM);

      if (bus.mw_en && w_tgt == TGT_OUT) r_io_out <= bus.D_out;

      // A clearing write wins over the free-running increment.
      if (bus.mw_en && w_tgt == TGT_CNT) r_cnt <= '0;
      else                               r_cnt <= r_cnt + 16'd1;

      if (w_tgt == TGT_NONE)                             r_bus_err <= 1'b1;
      else if (bus.mw_en && w_tgt == TGT_ERR && bus.D_out[0]) r_bus_err <= 1'b0;
    end
  end

  // RAM data is already registered inside data_ram; the select flop resets
  // to the I/O side so D_in reads zero while reset is held.
  assign bus.D_in = r_sel_ram ? w_ram_rdata : r_io_rdata;
  assign io_out   = r_io_out;
  assign bus_err  = r_bus_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM round trip, read-before-write,
// I/O page, counter clear/wrap, unmapped-access flag and mid-run reset.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic [15:0] sw_in;
  logic [15:0] io_out;
  logic        bus_err;

  int n_checks = 0;
  int n_pass   = 0;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .ADDR_W     (8),
    .IO_BASE    (16'hFF00),
    .RD_ERR_VAL (16'h0000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .sw_in   (sw_in),
    .io_out  (io_out),
    .bus_err (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    else
      n_pass++;
  endtask

  // One rising edge, then settle 1 ns so outputs are sampled away from it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [15:0] addr, input logic [15:0] data);
    bus.mw_en   = we;
    bus.Address = addr;
    bus.D_out   = data;
  endtask

  initial begin
    reset = 1'b0;
    sw_in = 16'h0000;
    drive(1'b0, 16'h0000, 16'h0000);
    #2;
    check("rst_d_in",    bus.D_in,       16'h0000);
    check("rst_io_out",  io_out,         16'h0000);
    check("rst_bus_err", 16'(bus_err),   16'h0000);

    @(negedge clk);
    reset = 1'b1;

    // RAM round trip
    drive(1'b1, 16'h0012, 16'hBEEF); cyc();
    drive(1'b0, 16'h0012, 16'h0000); cyc();
    check("ram_rt_1", bus.D_in, 16'hBEEF);
    cyc();
    check("ram_rt_2", bus.D_in, 16'hBEEF);

    // Read-before-write on the same edge
    drive(1'b1, 16'h0005, 16'h1111); cyc();
    drive(1'b1, 16'h0005, 16'h2222); cyc();
    check("rbw_old", bus.D_in, 16'h1111);
    drive(1'b0, 16'h0005, 16'h0000); cyc();
    check("rbw_new", bus.D_in, 16'h2222);

    // RAM top boundary and a marker for the unmapped-write test
    drive(1'b1, 16'h00FF, 16'hABCD); cyc();
    drive(1'b1, 16'h0007, 16'h7777); cyc();
    drive(1'b0, 16'h00FF, 16'h0000); cyc();
    check("ram_top", bus.D_in, 16'hABCD);
    check("ram_top_no_err", 16'(bus_err), 16'h0000);

    // Output port
    drive(1'b1, 16'hFF00, 16'h00A5); cyc();
    check("io_out_wr", io_out, 16'h00A5);
    drive(1'b0, 16'hFF00, 16'h0000); cyc();
    check("io_out_rd", bus.D_in, 16'h00A5);

    // Synchronized input port: visible on the third edge
    sw_in = 16'h3C3C;
    drive(1'b0, 16'hFF01, 16'h0000); cyc();
    check("sw_edge1", bus.D_in, 16'h0000);
    cyc();
    check("sw_edge2", bus.D_in, 16'h0000);
    cyc();
    check("sw_edge3", bus.D_in, 16'h3C3C);
    drive(1'b1, 16'hFF01, 16'h5555); cyc();
    check("sw_wr_no_err", 16'(bus_err), 16'h0000);

    // Counter clear then count
    drive(1'b1, 16'hFF02, 16'h1234); cyc();
    drive(1'b0, 16'hFF02, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("cnt_%0d", i), bus.D_in, 16'(i));
    end
    // Counter wrap: re-clear, then the read on edge n returns n-1
    drive(1'b1, 16'hFF02, 16'h0000); cyc();
    drive(1'b0, 16'hFF02, 16'h0000);
    repeat (65535) cyc();
    cyc();
    check("cnt_max", bus.D_in, 16'hFFFF);
    cyc();
    check("cnt_wrap", bus.D_in, 16'h0000);

    // Unmapped read
    drive(1'b0, 16'h1234, 16'h0000); cyc();
    check("unm_rd_data", bus.D_in,     16'h0000);
    check("unm_rd_err",  16'(bus_err), 16'h0001);
    drive(1'b0, 16'h0100, 16'h0000); cyc();
    check("ram_top_plus1_err", 16'(bus_err), 16'h0001);
    drive(1'b0, 16'hFF03, 16'h0000); cyc();
    check("err_reg_rd", bus.D_in, 16'h0001);

    // W1C of the error flag
    drive(1'b1, 16'hFF03, 16'h0000); cyc();
    check("w1c_zero_keeps", 16'(bus_err), 16'h0001);
    drive(1'b1, 16'hFF03, 16'h0001); cyc();
    check("w1c_clears", 16'(bus_err), 16'h0000);

    // Unmapped write: sets the flag, touches nothing
    drive(1'b1, 16'hFF07, 16'hDEAD); cyc();
    check("unm_wr_err", 16'(bus_err), 16'h0001);
    check("unm_wr_io",  io_out,       16'h00A5);
    drive(1'b0, 16'h0007, 16'h0000); cyc();
    check("unm_wr_ram", bus.D_in, 16'h7777);

    // Mid-run reset with io_out, counter and bus_err all non-zero
    drive(1'b1, 16'hFF00, 16'hFFFF); cyc();
    drive(1'b0, 16'hFF02, 16'h0000);
    repeat (100) cyc();
    drive(1'b0, 16'h4000, 16'h0000); cyc();
    check("pre_rst_io",  io_out,       16'hFFFF);
    check("pre_rst_err", 16'(bus_err), 16'h0001);
    drive(1'b0, 16'hFF02, 16'h0000);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_io",   io_out,       16'h0000);
    check("mid_rst_err",  16'(bus_err), 16'h0000);
    check("mid_rst_d_in", bus.D_in,     16'h0000);
    @(negedge clk);
    reset = 1'b1;
    cyc();
    check("post_rst_cnt", bus.D_in, 16'h0000);
    drive(1'b0, 16'h0012, 16'h0000); cyc();
    check("post_rst_ram", bus.D_in, 16'hBEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
